deserializer_lanes: RTL and testbench
=====================================

Name: deserializer_lanes

Overview:
- Parametrised successor to the single-bit deserializer.
- Collects LANES serial bits per beat into words of DATA_BUS_WIDTH bits, with selectable MSB- or LSB-first packing.
- Presents each completed word on a valid/ready output register, so downstream can stall without losing data.
- Sits between a serial link front end and the parallel datapath; optional flush emits partial words at frame ends.

Parameters:
- DATA_BUS_WIDTH, 16: output word width; must be a multiple of LANES.
- LANES, 1: serial bits accepted per beat; 1..DATA_BUS_WIDTH.
- LSB_FIRST, 0: 0 = first beat lands in MSBs; 1 = first beat lands in LSBs.
- BEATS, DATA_BUS_WIDTH/LANES: derived; beats per word; do not override.
- CNT_W, $clog2(BEATS+1): derived; beat counter width.

Ports:
- clk_i  in  1  clock.
- srst_i  in  1  synchronous active-high reset.
- data_i  in  LANES  serial bits for one beat.
- data_val_i  in  1  beat valid.
- data_ready_o  out  1  beat accepted when data_val_i && data_ready_o.
- deser_data_o  out  DATA_BUS_WIDTH  assembled word.
- deser_data_val_o  out  1  output word valid.
- deser_data_ready_i  in  1  downstream accepts word.
- flush_i  in  1  emit partial word (only with DESER_FLUSH_EN).
- deser_data_bits_o  out  CNT_W+$clog2(LANES)+1  valid bit count of output word (only with DESER_FLUSH_EN).

Behaviour:
- Reset: accumulator = 0, beat count = 0, deser_data_o = 0, deser_data_val_o = 0, deser_data_bits_o = 0. Reset mid-word discards the partial word and any held output word.
- out_free = !deser_data_val_o || deser_data_ready_i.
- data_ready_o = !(cnt == BEATS-1 && !out_free). This is combinational from deser_data_ready_i. Non-final beats are always accepted.
- MSB-first: beat k occupies bits [W-1-k*LANES -: LANES]. Within a beat, data_i[LANES-1] is the earliest bit.
- LSB-first: beat k occupies bits [k*LANES +: LANES]. Within a beat, data_i[0] is the earliest bit.
- Accepted non-final beat: write the beat slot, cnt += 1.
- Accepted final beat (cnt == BEATS-1): on the same edge, load the full word (including this beat) into the output register and set deser_data_val_o = 1. Then clear the accumulator to 0 and set cnt = 0.
- Latency: the word is visible the cycle after the final-beat edge.
- Output hold: while deser_data_val_o && !deser_data_ready_i, deser_data_o is stable.
- Output pop: on deser_data_val_o && deser_data_ready_i with no new word, set deser_data_val_o = 0 and deser_data_o = 0.
- Simultaneous pop and load: the new word replaces the old one; valid stays 1. Back-to-back words are possible every BEATS cycles with zero bubbles.
- LANES == DATA_BUS_WIDTH: every beat is final; throughput is one word per cycle while downstream is ready.
- cnt wraps only via the final-beat path. No overflow state exists because upstream is stalled instead.

Optional Feature:
- Macro: DESER_FLUSH_EN.
- With the macro: flush_i and deser_data_bits_o exist.
- Flush acts when flush_i && out_free && (cnt > 0 || a beat is accepted this cycle). The beat of the same cycle is included first.
- On flush: the word is loaded with unreceived positions = 0, deser_data_bits_o = (beats received) * LANES, the accumulator is cleared and cnt = 0.
- Full words report deser_data_bits_o = DATA_BUS_WIDTH.
- Flush with an empty accumulator and no beat is a no-op.
- Flush while !out_free is ignored; the requester must hold flush_i.
- If the same-cycle beat completes the word, the flush is absorbed by the normal full-word load.
- Without the macro: the ports are absent and there is no partial emission.

Test Plan:
- W=16, L=1, MSB-first, 16 beats of bits 1,0,1,0,... with ready high -> one cycle after the 16th beat, deser_data_o = 0xAAAA with valid for 1 cycle.
- W=16, L=4, beats 0xA,0xB,0xC,0xD, then 0x1,0x2,0x3,0x4 back-to-back -> 0xABCD, then 0x1234 four cycles later, no gaps.
- L=4, LSB_FIRST=1, beats 0xA,0xB,0xC,0xD -> 0xDCBA.
- L=4, deser_data_ready_i low holding 0xABCD while beats 0x1,0x2,0x3 arrive:
  - Beats 0x1–0x3 -> accepted; 4th beat -> data_ready_o = 0 until ready rises.
  - Ready rises -> 0xABCD popped and 0x1234 loaded on the same edge.
- srst_i asserted after 2 of 4 beats, then 4 beats 0x5,0x6,0x7,0x8 -> only 0x5678 emitted; valid 0 during reset.
- DESER_FLUSH_EN, L=4: beats 0xA,0xB,0xC, then flush_i -> 0xABC0, bits = 12. A second flush with an empty accumulator -> no output.

Source files
------------

// File: rtl/deserializer_lanes.sv
// Purpose : packs LANES serial bits per beat into DATA_BUS_WIDTH-bit words (MSB- or LSB-first).
// Latency : a word is valid on deser_data_o one cycle after the edge that accepts its final beat.
// Backpr. : non-final beats always accepted; the final beat stalls while the output register is full.
//
// Ports:
//   clk_i, srst_i                      clock, synchronous active-high reset
//   data_i/data_val_i/data_ready_o     serial beat input (valid/ready)
//   deser_data_o/_val_o/_ready_i       assembled word output register (valid/ready)
//   flush_i, deser_data_bits_o         partial-word emission and bit count (DESER_FLUSH_EN only)
//
// Optional feature macro: DESER_FLUSH_EN
module deserializer_lanes #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int LANES          = 1,
  parameter int LSB_FIRST      = 0,
  parameter int BEATS          = DATA_BUS_WIDTH / LANES,
  parameter int CNT_W          = $clog2(BEATS + 1)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [LANES-1:0]          data_i,
  input  logic                      data_val_i,
  output logic                      data_ready_o,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic                      deser_data_val_o,
  input  logic                      deser_data_ready_i
`ifdef DESER_FLUSH_EN
  ,
  input  logic                                 flush_i,
  output logic [CNT_W+$clog2(LANES)+1-1:0]     deser_data_bits_o
`endif
);

  localparam int W = DATA_BUS_WIDTH;

  logic [W-1:0]     acc_q;
  logic [W-1:0]     acc_merge;
  logic [CNT_W-1:0] cnt_q;
  logic             out_free;
  logic             final_beat;
  logic             beat_acc;
  logic             load_full;
  logic             flush_go;
  logic             load;
  int               slot_lo;

  assign out_free     = !deser_data_val_o || deser_data_ready_i;
  assign final_beat   = (cnt_q == CNT_W'(BEATS - 1));
  // Only the word-completing beat needs room in the output register.
  assign data_ready_o = !(final_beat && !out_free);
  assign beat_acc     = data_val_i && data_ready_o;
  assign load_full    = beat_acc && final_beat;
  assign load         = load_full || flush_go;

  // The accumulator is all-zero after every load/reset and each slot is
  // written exactly once per word, so OR-ing the beat in is sufficient.
  always_comb begin
    slot_lo   = (LSB_FIRST != 0) ? int'(cnt_q) * LANES
                                 : W - LANES - int'(cnt_q) * LANES;
    acc_merge = acc_q;
    if (beat_acc) begin
      acc_merge = acc_q | (W'(data_i) << slot_lo);
    end
  end

`ifdef DESER_FLUSH_EN
  localparam int BITS_W = CNT_W + $clog2(LANES) + 1;

  logic [BITS_W-1:0] bits_load;

  // A same-cycle final beat already produces a full word; the flush folds into it.
  assign flush_go  = flush_i && out_free && ((cnt_q != '0) || beat_acc) && !load_full;
  assign bits_load = load_full ? BITS_W'(W)
                               : (BITS_W'(cnt_q) + BITS_W'(beat_acc)) * BITS_W'(LANES);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      deser_data_bits_o <= '0;
    end else if (load) begin
      deser_data_bits_o <= bits_load;
    end else if (deser_data_val_o && deser_data_ready_i) begin
      deser_data_bits_o <= '0;
    end
  end
`else
  assign flush_go = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q            <= '0;
      cnt_q            <= '0;
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      if (load) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (beat_acc) begin
        acc_q <= acc_merge;
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // A new word overwrites the one being popped, so back-to-back words have no bubble.
      if (load) begin
        deser_data_o     <= acc_merge;
        deser_data_val_o <= 1'b1;
      end else if (deser_data_val_o && deser_data_ready_i) begin
        deser_data_o     <= '0;
        deser_data_val_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_lanes.sv
module tb_deserializer_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst;

  // Instance A: W=16, L=4, MSB-first
  logic [3:0]  a_dat;
  logic        a_val, a_rdy, a_oval, a_ordy;
  logic [15:0] a_out;
  // Instance B: W=16, L=1, MSB-first
  logic [0:0]  b_dat;
  logic        b_val, b_rdy, b_oval, b_ordy;
  logic [15:0] b_out;
  // Instance C: W=16, L=4, LSB-first
  logic [3:0]  c_dat;
  logic        c_val, c_rdy, c_oval, c_ordy;
  logic [15:0] c_out;
`ifdef DESER_FLUSH_EN
  logic        a_flush, b_flush, c_flush;
  logic [5:0]  a_bits, b_bits, c_bits;
`endif

  int vectors     = 0;
  int miscompares = 0;

  deserializer_lanes #(.DATA_BUS_WIDTH(16), .LANES(4), .LSB_FIRST(0)) u_a (
    .clk_i(clk), .srst_i(srst), .data_i(a_dat), .data_val_i(a_val), .data_ready_o(a_rdy),
    .deser_data_o(a_out), .deser_data_val_o(a_oval), .deser_data_ready_i(a_ordy)
`ifdef DESER_FLUSH_EN
    , .flush_i(a_flush), .deser_data_bits_o(a_bits)
`endif
  );

  deserializer_lanes #(.DATA_BUS_WIDTH(16), .LANES(1), .LSB_FIRST(0)) u_b (
    .clk_i(clk), .srst_i(srst), .data_i(b_dat), .data_val_i(b_val), .data_ready_o(b_rdy),
    .deser_data_o(b_out), .deser_data_val_o(b_oval), .deser_data_ready_i(b_ordy)
`ifdef DESER_FLUSH_EN
    , .flush_i(b_flush), .deser_data_bits_o(b_bits)
`endif
  );

  deserializer_lanes #(.DATA_BUS_WIDTH(16), .LANES(4), .LSB_FIRST(1)) u_c (
    .clk_i(clk), .srst_i(srst), .data_i(c_dat), .data_val_i(c_val), .data_ready_o(c_rdy),
    .deser_data_o(c_out), .deser_data_val_o(c_oval), .deser_data_ready_i(c_ordy)
`ifdef DESER_FLUSH_EN
    , .flush_i(c_flush), .deser_data_bits_o(c_bits)
`endif
  );

  // Stimulus helpers: drive on the falling edge, observe 1 time unit after the rising edge.
  task automatic set_a(input logic v, input logic [3:0] d, input logic r);
    @(negedge clk);
    a_val = v; a_dat = d; a_ordy = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    srst = 1'b1;
    a_val = 0; a_dat = 0; a_ordy = 1;
    b_val = 0; b_dat = 0; b_ordy = 1;
    c_val = 0; c_dat = 0; c_ordy = 1;
`ifdef DESER_FLUSH_EN
    a_flush = 0; b_flush = 0; c_flush = 0;
`endif
    tick; tick;
    vectors++;
    if (a_out !== 16'h0 || a_oval !== 1'b0) begin
      miscompares++; $display("FAIL reset_a: out=%h val=%b want 0000/0", a_out, a_oval);
    end
    vectors++;
    if (b_oval !== 1'b0 || c_oval !== 1'b0 || b_out !== 16'h0 || c_out !== 16'h0) begin
      miscompares++; $display("FAIL reset_bc: bval=%b cval=%b bout=%h cout=%h want 0", b_oval, c_oval, b_out, c_out);
    end
    vectors++;
    if (a_rdy !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", a_rdy);
    end
`ifdef DESER_FLUSH_EN
    vectors++;
    if (a_bits !== 6'd0) begin
      miscompares++; $display("FAIL reset_bits: got %0d want 0", a_bits);
    end
`endif
    @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic test_single_lane;
    b_ordy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_val = 1'b1; b_dat = 1'((i % 2) == 0);
      #1;
      vectors++;
      if (b_rdy !== 1'b1) begin
        miscompares++; $display("FAIL l1_ready beat %0d: got %b want 1", i, b_rdy);
      end
      tick;
      if (i == 14) begin
        vectors++;
        if (b_oval !== 1'b0) begin
          miscompares++; $display("FAIL l1_early_valid: got %b want 0", b_oval);
        end
      end
    end
    vectors++;
    if (b_oval !== 1'b1 || b_out !== 16'hAAAA) begin
      miscompares++; $display("FAIL l1_word: out=%h val=%b want aaaa/1", b_out, b_oval);
    end
    @(negedge clk);
    b_val = 1'b0;
    tick;
    vectors++;
    if (b_oval !== 1'b0 || b_out !== 16'h0) begin
      miscompares++; $display("FAIL l1_pop: out=%h val=%b want 0000/0", b_out, b_oval);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] beats [8];
    beats = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, beats[i], 1'b1);
      vectors++;
      if (a_rdy !== 1'b1) begin
        miscompares++; $display("FAIL b2b_ready beat %0d: got %b want 1", i, a_rdy);
      end
      tick;
      if (i == 3) begin
        vectors++;
        if (a_oval !== 1'b1 || a_out !== 16'hABCD) begin
          miscompares++; $display("FAIL b2b_word0: out=%h val=%b want abcd/1", a_out, a_oval);
        end
      end
      if (i == 4) begin
        vectors++;
        if (a_oval !== 1'b0) begin
          miscompares++; $display("FAIL b2b_pop: val=%b want 0", a_oval);
        end
      end
    end
    vectors++;
    if (a_oval !== 1'b1 || a_out !== 16'h1234) begin
      miscompares++; $display("FAIL b2b_word1: out=%h val=%b want 1234/1", a_out, a_oval);
    end
    set_a(1'b0, 4'h0, 1'b1);
    tick;
  endtask

  task automatic test_lsb_first;
    logic [3:0] beats [4];
    beats = '{4'hA, 4'hB, 4'hC, 4'hD};
    c_ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c_val = 1'b1; c_dat = beats[i];
      tick;
    end
    vectors++;
    if (c_oval !== 1'b1 || c_out !== 16'hDCBA || c_rdy !== 1'b1) begin
      miscompares++; $display("FAIL lsb_word: out=%h val=%b rdy=%b want dcba/1/1", c_out, c_oval, c_rdy);
    end
    @(negedge clk);
    c_val = 1'b0;
    tick;
  endtask

  task automatic test_stall;
    logic [3:0] beats [4];
    beats = '{4'hA, 4'hB, 4'hC, 4'hD};
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, beats[i], 1'b1);
      tick;
    end
    for (int i = 1; i <= 3; i++) begin
      set_a(1'b1, 4'(i), 1'b0);
      vectors++;
      if (a_rdy !== 1'b1) begin
        miscompares++; $display("FAIL stall_nonfinal_ready beat %0d: got %b want 1", i, a_rdy);
      end
      tick;
      vectors++;
      if (a_oval !== 1'b1 || a_out !== 16'hABCD) begin
        miscompares++; $display("FAIL stall_hold %0d: out=%h val=%b want abcd/1", i, a_out, a_oval);
      end
    end
    for (int i = 0; i < 2; i++) begin
      set_a(1'b1, 4'h4, 1'b0);
      vectors++;
      if (a_rdy !== 1'b0) begin
        miscompares++; $display("FAIL stall_final_ready %0d: got %b want 0", i, a_rdy);
      end
      tick;
      vectors++;
      if (a_oval !== 1'b1 || a_out !== 16'hABCD) begin
        miscompares++; $display("FAIL stall_hold_final %0d: out=%h val=%b want abcd/1", i, a_out, a_oval);
      end
    end
    set_a(1'b1, 4'h4, 1'b1);
    vectors++;
    if (a_rdy !== 1'b1) begin
      miscompares++; $display("FAIL stall_release_ready: got %b want 1", a_rdy);
    end
    tick;
    vectors++;
    if (a_oval !== 1'b1 || a_out !== 16'h1234) begin
      miscompares++; $display("FAIL stall_replace: out=%h val=%b want 1234/1", a_out, a_oval);
    end
    set_a(1'b0, 4'h0, 1'b1);
    tick;
  endtask

  task automatic test_mid_reset;
    logic [3:0] beats [4];
    beats = '{4'hF, 4'hE, 4'hD, 4'hC};
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, beats[i], 1'b0);
      tick;
    end
    set_a(1'b1, 4'h9, 1'b0); tick;
    set_a(1'b1, 4'h3, 1'b0); tick;
    @(negedge clk);
    srst = 1'b1; a_val = 1'b0;
    tick;
    vectors++;
    if (a_oval !== 1'b0 || a_out !== 16'h0 || a_rdy !== 1'b1) begin
      miscompares++; $display("FAIL midrst_state: out=%h val=%b rdy=%b want 0000/0/1", a_out, a_oval, a_rdy);
    end
    @(negedge clk);
    srst = 1'b0;
    beats = '{4'h5, 4'h6, 4'h7, 4'h8};
    for (int i = 0; i < 4; i++) begin
      set_a(1'b1, beats[i], 1'b1);
      tick;
      if (i < 3) begin
        vectors++;
        if (a_oval !== 1'b0) begin
          miscompares++; $display("FAIL midrst_stale beat %0d: val=%b out=%h want 0", i, a_oval, a_out);
        end
      end
    end
    vectors++;
    if (a_oval !== 1'b1 || a_out !== 16'h5678) begin
      miscompares++; $display("FAIL midrst_word: out=%h val=%b want 5678/1", a_out, a_oval);
    end
    set_a(1'b0, 4'h0, 1'b1);
    tick;
  endtask

`ifdef DESER_FLUSH_EN
  task automatic test_flush;
    logic [3:0] beats [3];
    beats = '{4'hA, 4'hB, 4'hC};
    for (int i = 0; i < 3; i++) begin
      set_a(1'b1, beats[i], 1'b1);
      tick;
    end
    set_a(1'b0, 4'h0, 1'b1);
    a_flush = 1'b1;
    tick;
    vectors++;
    if (a_oval !== 1'b1 || a_out !== 16'hABC0 || a_bits !== 6'd12) begin
      miscompares++; $display("FAIL flush_partial: out=%h val=%b bits=%0d want abc0/1/12", a_out, a_oval, a_bits);
    end
    tick;
    vectors++;
    if (a_oval !== 1'b0 || a_bits !== 6'd0) begin
      miscompares++; $display("FAIL flush_empty: val=%b bits=%0d want 0/0", a_oval, a_bits);
    end
    a_flush = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_a(1'b1, 4'(i), 1'b1);
      tick;
    end
    set_a(1'b1, 4'h4, 1'b1);
    a_flush = 1'b1;
    tick;
    vectors++;
    if (a_oval !== 1'b1 || a_out !== 16'h1234 || a_bits !== 6'd16) begin
      miscompares++; $display("FAIL flush_absorbed: out=%h val=%b bits=%0d want 1234/1/16", a_out, a_oval, a_bits);
    end
    a_flush = 1'b0;
    set_a(1'b0, 4'h0, 1'b1);
    tick;
  endtask
`endif

  // Reference model: an ordered list of received beats and a one-entry output slot.
  task automatic test_random;
    int          nb;
    int          bt [4];
    logic        mfull;
    logic [15:0] mword;
    int          mbits;
    logic        v, r, f, exp_rdy, acc, ofree;
    logic [3:0]  d;
    logic [15:0] w;

    @(negedge clk);
    srst = 1'b1; a_val = 0; a_ordy = 1;
    tick;
    @(negedge clk);
    srst = 1'b0;
    nb = 0; mfull = 1'b0; mword = '0; mbits = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = 4'($urandom_range(0, 15));
      f = 1'b0;
`ifdef DESER_FLUSH_EN
      f = ($urandom_range(0, 6) == 0);
      a_flush = f;
`endif
      set_a(v, d, r);

      exp_rdy = !((nb == 3) && mfull && !r);
      vectors++;
      if (a_rdy !== exp_rdy) begin
        miscompares++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, a_rdy, exp_rdy);
      end

      acc   = v && exp_rdy;
      ofree = !mfull || r;
      if (acc) begin
        bt[nb] = int'(d);
        nb++;
      end
      w = '0;
      for (int k = 0; k < nb; k++) w = w | (16'(bt[k]) << (16 - 4 * (k + 1)));
      if (nb == 4) begin
        mfull = 1'b1; mword = w; mbits = 16; nb = 0;
      end else if (f && ofree && nb > 0) begin
        mfull = 1'b1; mword = w; mbits = nb * 4; nb = 0;
      end else if (mfull && r) begin
        mfull = 1'b0; mword = '0; mbits = 0;
      end

      tick;
      vectors++;
      if (a_oval !== mfull || a_out !== mword) begin
        miscompares++; $display("FAIL rand_out cyc %0d: out=%h val=%b want %h/%b", cyc, a_out, a_oval, mword, mfull);
      end
`ifdef DESER_FLUSH_EN
      vectors++;
      if (a_bits !== 6'(mbits)) begin
        miscompares++; $display("FAIL rand_bits cyc %0d: got %0d want %0d", cyc, a_bits, mbits);
      end
`endif
    end
`ifdef DESER_FLUSH_EN
    a_flush = 1'b0;
`endif
    set_a(1'b0, 4'h0, 1'b1);
    tick;
  endtask

  initial begin
    test_reset;
    test_single_lane;
    test_back_to_back;
    test_lsb_first;
    test_stall;
    test_mid_reset;
`ifdef DESER_FLUSH_EN
    test_flush;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
